y86_seq_ctrl: RTL and testbench

Y86_SEQ_CTRL -- requirements
Module: y86_seq_ctrl

---
 rtl/y86_pkg.sv | 40 ++++
 rtl/y86_pc_select.sv | 22 ++
 rtl/y86_seq_ctrl.sv | 117 +++++++++++
 tb/tb_y86_seq_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared definitions for the Y86-64 sequential controller: instruction codes,
// status codes and the controller state encoding.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_PCUPD     = 3'd6,
    S_HALTED    = 3'd7
  } state_t;

  // Instructions that touch data memory and therefore need the MEMORY stage.
  function automatic logic needs_memory(input logic [3:0] code);
    return (code == I_RMMOVQ) || (code == I_MRMOVQ) || (code == I_CALL) ||
           (code == I_RET)    || (code == I_PUSHQ)  || (code == I_POPQ);
  endfunction

endpackage

// File: rtl/y86_pc_select.sv
// Next-PC mux: taken jumps and calls go to valC, ret to the popped return
// address, everything else falls through to valP.
module y86_pc_select
  import y86_pkg::*;
(
  input  logic [3:0]  icode,
  input  logic        cnd,
  input  logic [63:0] valC,
  input  logic [63:0] valP,
  input  logic [63:0] valM,
  output logic [63:0] next_pc
);

  always_comb begin
    next_pc = valP;
    if ((icode == I_JXX && cnd) || icode == I_CALL)
      next_pc = valC;
    else if (icode == I_RET)
      next_pc = valM;
  end

endmodule

// File: rtl/y86_seq_ctrl.sv
// Sequential (non-pipelined) Y86-64 controller: steps one instruction at a time
// through the stage strobes, tracks status, PC and the retired-instruction count.
module y86_seq_ctrl
  import y86_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  icode,
  input  logic [3:0]  ifun,
  input  logic [63:0] valC,
  input  logic [63:0] valP,
  input  logic        instr_val,
  input  logic        imem_er,
  input  logic        halt,
  input  logic        cnd,
  input  logic [63:0] valM,
  input  logic        dmem_er,
  output logic [63:0] PC,
  output logic        en_fetch,
  output logic        en_decode,
  output logic        en_execute,
  output logic        en_memory,
  output logic        en_writeback,
  output logic [2:0]  stat,
  output logic        busy,
  output logic [63:0] instr_count
);

  state_t      state_reg, state_next;
  logic [63:0] pc_reg, count_reg, valc_reg, valp_reg, valm_reg, next_pc;
  logic [3:0]  icode_reg, ifun_reg;
  logic [2:0]  stat_reg;
  logic        cnd_reg;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:      if (start) state_next = S_FETCH;
      S_FETCH:     state_next = (imem_er || !instr_val || halt) ? S_HALTED : S_DECODE;
      S_DECODE:    state_next = S_EXECUTE;
      S_EXECUTE:   state_next = needs_memory(icode_reg) ? S_MEMORY : S_WRITEBACK;
      S_MEMORY:    state_next = dmem_er ? S_HALTED : S_WRITEBACK;
      S_WRITEBACK: state_next = S_PCUPD;
      S_PCUPD:     state_next = S_FETCH;
      S_HALTED:    state_next = S_HALTED;
      default:     state_next = S_IDLE;
    endcase
  end

  always_comb begin
    en_fetch     = (state_reg == S_FETCH);
    en_decode    = (state_reg == S_DECODE);
    en_execute   = (state_reg == S_EXECUTE);
    en_memory    = (state_reg == S_MEMORY);
    en_writeback = (state_reg == S_WRITEBACK);
    busy         = (state_reg != S_IDLE) && (state_reg != S_HALTED);
  end

  // Halting exits never reach PCUPD, so PC and the count stay on the faulting instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg    <= RESET_PC;
      stat_reg  <= STAT_AOK;
      count_reg <= 64'd0;
      icode_reg <= 4'd0;
      ifun_reg  <= 4'd0;
      valc_reg  <= 64'd0;
      valp_reg  <= 64'd0;
      valm_reg  <= 64'd0;
      cnd_reg   <= 1'b0;
    end else begin
      case (state_reg)
        S_FETCH: begin
          icode_reg <= icode;
          ifun_reg  <= ifun;
          valc_reg  <= valC;
          valp_reg  <= valP;
          if (imem_er)         stat_reg <= STAT_ADR;
          else if (!instr_val) stat_reg <= STAT_INS;
          else if (halt)       stat_reg <= STAT_HLT;
        end
        S_EXECUTE: cnd_reg <= cnd;
        S_MEMORY: begin
          valm_reg <= valM;
          if (dmem_er) stat_reg <= STAT_ADR;
        end
        S_PCUPD: begin
          pc_reg    <= next_pc;
          count_reg <= count_reg + 64'd1;
        end
        default: ;
      endcase
    end
  end

  y86_pc_select u_pc_select (
    .icode   (icode_reg),
    .cnd     (cnd_reg),
    .valC    (valc_reg),
    .valP    (valp_reg),
    .valM    (valm_reg),
    .next_pc (next_pc)
  );

  assign PC          = pc_reg;
  assign stat        = stat_reg;
  assign instr_count = count_reg;

endmodule

// File: tb/tb_y86_seq_ctrl.sv
// Directed bench for y86_seq_ctrl: nop, jumps, call/ret, status faults,
// data-memory fault and reset in the middle of an instruction.
module tb_y86_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, instr_val, imem_er, halt, cnd, dmem_er;
  logic [3:0]  icode, ifun;
  logic [63:0] valC, valP, valM;
  logic [63:0] PC, instr_count;
  logic        en_fetch, en_decode, en_execute, en_memory, en_writeback, busy;
  logic [2:0]  stat;

  int checks = 0;
  int errors = 0;
  int cycles;
  bit saw_mem;

  always #5 clk = ~clk;

  y86_seq_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .icode(icode), .ifun(ifun),
    .valC(valC), .valP(valP), .instr_val(instr_val), .imem_er(imem_er),
    .halt(halt), .cnd(cnd), .valM(valM), .dmem_er(dmem_er), .PC(PC),
    .en_fetch(en_fetch), .en_decode(en_decode), .en_execute(en_execute),
    .en_memory(en_memory), .en_writeback(en_writeback), .stat(stat),
    .busy(busy), .instr_count(instr_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
    $display("check %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  function automatic logic [63:0] strobes();
    return {59'd0, en_fetch, en_decode, en_execute, en_memory, en_writeback};
  endfunction

  task automatic do_reset();
    rst = 1'b1; start = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // From FETCH, run until the next FETCH or a stop; bounded at 20 cycles.
  task automatic run_instr(output int n, output bit mem);
    n = 0; mem = 1'b0;
    do begin
      tick();
      n++;
      if (en_memory) mem = 1'b1;
    end while (!en_fetch && busy && n < 20);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; icode = 4'd1; ifun = 4'd0;
    valC = 64'd0; valP = 64'd1; valM = 64'd0;
    instr_val = 1'b1; imem_er = 1'b0; halt = 1'b0; cnd = 1'b0; dmem_er = 1'b0;

    // Reset state
    do_reset();
    chk("reset_pc", PC, 64'd0);
    chk("reset_stat", {61'd0, stat}, 64'd1);
    chk("reset_count", instr_count, 64'd0);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_strobes", strobes(), 64'd0);

    // nop
    do_start();
    chk("nop_fetch_entered", {63'd0, en_fetch}, 64'd1);
    chk("nop_busy", {63'd0, busy}, 64'd1);
    run_instr(cycles, saw_mem);
    chk("nop_cycles", cycles, 64'd5);
    chk("nop_pc", PC, 64'd1);
    chk("nop_count", instr_count, 64'd1);
    chk("nop_no_memory", {63'd0, saw_mem}, 64'd0);

    // jXX taken
    do_reset();
    icode = 4'd7; valC = 64'h40; valP = 64'd9; cnd = 1'b1;
    do_start();
    run_instr(cycles, saw_mem);
    chk("jxx_taken_cycles", cycles, 64'd5);
    chk("jxx_taken_pc", PC, 64'h40);

    // jXX not taken
    do_reset();
    cnd = 1'b0;
    do_start();
    run_instr(cycles, saw_mem);
    chk("jxx_nt_pc", PC, 64'd9);

    // call then ret
    do_reset();
    icode = 4'd8; valC = 64'h100; valP = 64'd9; valM = 64'hDEAD;
    do_start();
    run_instr(cycles, saw_mem);
    chk("call_cycles", cycles, 64'd6);
    chk("call_memory", {63'd0, saw_mem}, 64'd1);
    chk("call_pc", PC, 64'h100);
    icode = 4'd9; valC = 64'h555; valP = 64'h101; valM = 64'h0A;
    run_instr(cycles, saw_mem);
    chk("ret_cycles", cycles, 64'd6);
    chk("ret_pc", PC, 64'h0A);
    chk("ret_count", instr_count, 64'd2);

    // imem_er has priority over !instr_val
    do_reset();
    icode = 4'd1; valP = 64'd1; imem_er = 1'b1; instr_val = 1'b0;
    do_start();
    tick();
    chk("imem_stat", {61'd0, stat}, 64'd3);
    chk("imem_halted_busy", {63'd0, busy}, 64'd0);
    chk("imem_strobes", strobes(), 64'd0);

    // invalid instruction
    do_reset();
    imem_er = 1'b0; instr_val = 1'b0;
    do_start();
    tick();
    chk("ins_stat", {61'd0, stat}, 64'd4);

    // nop then halt; start afterwards ignored
    do_reset();
    instr_val = 1'b1; icode = 4'd1; valP = 64'd5;
    do_start();
    run_instr(cycles, saw_mem);
    chk("pre_halt_pc", PC, 64'd5);
    icode = 4'd0; valP = 64'd6; halt = 1'b1;
    tick();
    chk("hlt_stat", {61'd0, stat}, 64'd2);
    chk("hlt_pc", PC, 64'd5);
    chk("hlt_count", instr_count, 64'd1);
    halt = 1'b0; icode = 4'd1;
    do_start();
    tick(); tick();
    chk("halted_start_busy", {63'd0, busy}, 64'd0);
    chk("halted_start_strobes", strobes(), 64'd0);
    chk("halted_start_pc", PC, 64'd5);
    chk("halted_start_stat", {61'd0, stat}, 64'd2);

    // mrmovq with data-memory fault
    do_reset();
    icode = 4'd5; valP = 64'd10; dmem_er = 1'b1;
    do_start();
    tick(); tick(); tick();
    chk("mrm_in_memory", strobes(), 64'b00010);
    tick();
    chk("mrm_stat", {61'd0, stat}, 64'd3);
    chk("mrm_count", instr_count, 64'd0);
    chk("mrm_pc", PC, 64'd0);
    chk("mrm_busy", {63'd0, busy}, 64'd0);
    dmem_er = 1'b0;

    // reset during EXECUTE of the second instruction
    do_reset();
    icode = 4'd1; valP = 64'd7;
    do_start();
    run_instr(cycles, saw_mem);
    chk("pre_rst_pc", PC, 64'd7);
    tick(); tick();
    chk("in_execute", strobes(), 64'b00100);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_pc", PC, 64'd0);
    chk("mid_rst_stat", {61'd0, stat}, 64'd1);
    chk("mid_rst_busy", {63'd0, busy}, 64'd0);
    chk("mid_rst_strobes", strobes(), 64'd0);
    chk("mid_rst_count", instr_count, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
